// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency backing memory between the
// instruction-fetch and data ports of a zero-latency-style core.
// Data accesses take priority over fetches, and only one backing transaction
// is outstanding at a time. Each port has a one-entry result buffer.
// Optional feature macro: ARB_PERF_EN adds saturating stall/busy counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    // fetch port
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_instr,
    output logic              i_stall,
    // data port
    input  logic              d_en,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wd,
    output logic [DATA_W-1:0] d_rd,
    output logic              d_stall,
    // backing memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_i_stall,
    output logic [PERF_W-1:0] perf_d_stall,
    output logic [PERF_W-1:0] perf_busy
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        RESP_I = 3'd2,
        REQ_D  = 3'd3,
        RESP_D = 3'd4
    } state_t;

    // A zero-width counter makes no sense when the counters are built.
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("PERF_W must be at least 1");
    end

    state_t            r_state;
    logic              r_mem_req;
    logic              r_i_valid;
    logic [ADDR_W-1:0] r_i_tag;
    logic [DATA_W-1:0] r_i_data;
    logic              r_d_done;
    logic [ADDR_W-1:0] r_d_tag;
    logic              r_d_tag_we;
    logic [DATA_W-1:0] r_d_data;
    logic [ADDR_W-1:0] r_lat_addr;
    logic              r_lat_we;
    logic [DATA_W-1:0] r_lat_wd;

    logic              w_i_hit;
    logic              w_d_hit;

    // Buffer hit detection against the current core request.
    always_comb begin
        w_i_hit = r_i_valid && (r_i_tag == i_addr);
        w_d_hit = r_d_done && (r_d_tag == d_addr) && (r_d_tag_we == d_we);
    end

    assign i_stall  = i_en && !w_i_hit;
    assign i_instr  = r_i_data;
    assign d_stall  = d_en && !w_d_hit;
    assign d_rd     = r_d_data;

    // Backing request fields come from the latched registers so they stay
    // stable for as long as mem_ready is held low.
    assign mem_req  = r_mem_req;
    assign mem_we   = r_lat_we;
    assign mem_addr = r_lat_addr;
    assign mem_wd   = r_lat_wd;

    // Arbitration/sequencing FSM plus result buffers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_i_valid  <= 1'b0;
            r_i_tag    <= '0;
            r_i_data   <= '0;
            r_d_done   <= 1'b0;
            r_d_tag    <= '0;
            r_d_tag_we <= 1'b0;
            r_d_data   <= '0;
            r_lat_addr <= '0;
            r_lat_we   <= 1'b0;
            r_lat_wd   <= '0;
        end else begin
            // A data result is handed over exactly once, and dropped if the
            // core stops asking; a same-edge fill below takes precedence.
            if (!d_en || w_d_hit) begin
                r_d_done <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (d_en && !w_d_hit) begin
                        r_lat_addr <= d_addr;
                        r_lat_we   <= d_we;
                        r_lat_wd   <= d_wd;
                        r_mem_req  <= 1'b1;
                        r_state    <= REQ_D;
                    end else if (i_en && !w_i_hit) begin
                        r_lat_addr <= i_addr;
                        r_lat_we   <= 1'b0;
                        r_lat_wd   <= '0;
                        r_mem_req  <= 1'b1;
                        r_state    <= REQ_I;
                    end
                end
                REQ_I: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP_I;
                    end
                end
                RESP_I: begin
                    if (mem_rvalid) begin
                        r_i_valid <= 1'b1;
                        r_i_tag   <= r_lat_addr;
                        r_i_data  <= mem_rdata;
                        r_state   <= IDLE;
                    end
                end
                REQ_D: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP_D;
                    end
                end
                RESP_D: begin
                    if (mem_rvalid) begin
                        r_d_done   <= 1'b1;
                        r_d_tag    <= r_lat_addr;
                        r_d_tag_we <= r_lat_we;
                        r_d_data   <= mem_rdata;
                        // A store over the buffered instruction invalidates it.
                        if (r_lat_we && (r_lat_addr == r_i_tag)) begin
                            r_i_valid <= 1'b0;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    logic [PERF_W-1:0] r_perf_i_stall;
    logic [PERF_W-1:0] r_perf_d_stall;
    logic [PERF_W-1:0] r_perf_busy;

    assign perf_i_stall = r_perf_i_stall;
    assign perf_d_stall = r_perf_d_stall;
    assign perf_busy    = r_perf_busy;

    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_i_stall <= '0;
            r_perf_d_stall <= '0;
            r_perf_busy    <= '0;
        end else begin
            if (i_stall && !(&r_perf_i_stall)) begin
                r_perf_i_stall <= r_perf_i_stall + PERF_W'(1);
            end
            if (d_stall && !(&r_perf_d_stall)) begin
                r_perf_d_stall <= r_perf_d_stall + PERF_W'(1);
            end
            if ((r_state != IDLE) && !(&r_perf_busy)) begin
                r_perf_busy <= r_perf_busy + PERF_W'(1);
            end
        end
    end
`endif

endmodule
